// File: rtl/pulse_indicator_pkg.sv
// Shared state encoding and default timing constants for the LED pulse indicator.
package pulse_indicator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  localparam int DEF_ON_CYCLES  = 5000000;
  localparam int DEF_OFF_CYCLES = 5000000;
  localparam int DEF_SIM_CYCLES = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_indicator_driver_blink_timer.sv
// Loadable down-counter that times the ON and OFF phases of a blink.
module blink_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Load wins over decrement; the counter parks at zero until reloaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_indicator_driver.sv
// Turns single-cycle event pulses into visible LED blinks, queueing events that arrive mid-blink.
// Define LED_ACTIVE_LOW_EN to drive led_out active-low.
module pulse_indicator_driver
  import pulse_indicator_pkg::*;
#(
  parameter bit sim        = 1'b0,
  parameter int ON_CYCLES  = DEF_ON_CYCLES,
  parameter int OFF_CYCLES = DEF_OFF_CYCLES,
  parameter int SIM_CYCLES = DEF_SIM_CYCLES,
  parameter int PEND_W     = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic pulse_in,
  output logic led_out,
  output logic busy,
  output logic overflow
);

  localparam int T_ON  = sim ? SIM_CYCLES : ON_CYCLES;
  localparam int T_OFF = sim ? SIM_CYCLES : OFF_CYCLES;
  localparam int TMR_W = $clog2(max_int(T_ON, T_OFF)) + 1;

  localparam logic [TMR_W-1:0]  ON_LOAD  = TMR_W'(T_ON - 1);
  localparam logic [TMR_W-1:0]  OFF_LOAD = TMR_W'(T_OFF - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  state_t              state, state_next;
  logic                pulse_in_d;
  logic                evt;
  logic [PEND_W-1:0]   pending, pending_next;
  logic                overflow_next;
  logic                led_next, busy_next;
  logic                load;
  logic [TMR_W-1:0]    load_val;
  logic                zero;
  logic                active, full, consume, accept, drop;

  blink_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  assign evt = pulse_in & ~pulse_in_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      pulse_in_d <= 1'b0;
      pending    <= '0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
`ifdef LED_ACTIVE_LOW_EN
      led_out    <= 1'b1;
`else
      led_out    <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      pulse_in_d <= pulse_in;
      pending    <= pending_next;
      overflow   <= overflow_next;
      busy       <= busy_next;
`ifdef LED_ACTIVE_LOW_EN
      led_out    <= ~led_next;
`else
      led_out    <= led_next;
`endif
    end
  end

  // A same-cycle event counts toward the end-of-OFF consume, so it is never lost.
  always_comb begin
    state_next    = state;
    load          = 1'b0;
    load_val      = ON_LOAD;
    pending_next  = pending;
    overflow_next = overflow;

    active  = (state != ST_IDLE);
    full    = (pending == PEND_MAX);
    consume = (state == ST_OFF) && zero && ((pending != '0) || evt);
    accept  = evt && active && (!full || consume);
    drop    = evt && active && full && !consume;

    if (accept && !consume) begin
      pending_next = pending + PEND_W'(1);
    end else if (consume && !accept) begin
      pending_next = pending - PEND_W'(1);
    end

    if (drop) begin
      overflow_next = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (evt) begin
          state_next = ST_ON;
          load       = 1'b1;
          load_val   = ON_LOAD;
        end
      end
      ST_ON: begin
        if (zero) begin
          state_next = ST_OFF;
          load       = 1'b1;
          load_val   = OFF_LOAD;
        end
      end
      ST_OFF: begin
        if (zero) begin
          if (consume) begin
            state_next = ST_ON;
            load       = 1'b1;
            load_val   = ON_LOAD;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    led_next  = (state_next == ST_ON);
    busy_next = (state_next != ST_IDLE) || (pending_next != '0);
  end

endmodule

// File: tb/tb_pulse_indicator_driver.sv
// Directed self-checking bench for pulse_indicator_driver (sim=1, SIM_CYCLES=4, PEND_W=3).
module tb_pulse_indicator_driver;

`ifdef LED_ACTIVE_LOW_EN
  localparam logic LED_ON = 1'b0;
`else
  localparam logic LED_ON = 1'b1;
`endif
  localparam logic LED_OFF = ~LED_ON;

  logic clk = 1'b0;
  logic reset;
  logic pulse_in;
  logic led_out;
  logic busy;
  logic overflow;

  int   checks   = 0;
  int   failures = 0;
  int   blinks   = 0;
  logic led_prev = 1'b0;

  pulse_indicator_driver #(
    .sim        (1'b1),
    .SIM_CYCLES (4),
    .PEND_W     (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pulse_in (pulse_in),
    .led_out  (led_out),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Advance one clock and sample 1 time unit after the edge; counts LED rising edges.
  task automatic step();
    @(posedge clk);
    #1;
    if (led_out === LED_ON && led_prev !== LED_ON) blinks++;
    led_prev = led_out;
  endtask

  task automatic do_reset();
    pulse_in = 1'b0;
    reset    = 1'b1;
    step();
    step();
    reset    = 1'b0;
    step();
    blinks   = 0;
    led_prev = led_out;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (led_out !== LED_OFF) begin
      failures++;
      $display("[TB] FAIL reset_led got=%b exp=%b", led_out, LED_OFF);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_busy got=%b exp=0", busy);
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_overflow got=%b exp=0", overflow);
    end
  endtask

  // Pulse in cycle 0: LED on cycles 1..4, busy cycles 1..8, idle at 9.
  task automatic test_single_pulse();
    logic exp_led, exp_busy;
    for (int off = 0; off < 10; off++) begin
      pulse_in = (off == 0);
      step();
      exp_led  = ((off + 1) >= 1 && (off + 1) <= 4) ? LED_ON : LED_OFF;
      exp_busy = ((off + 1) <= 8);
      checks++;
      if (led_out !== exp_led) begin
        failures++;
        $display("[TB] FAIL single_led n=%0d got=%b exp=%b", off + 1, led_out, exp_led);
      end
      checks++;
      if (busy !== exp_busy) begin
        failures++;
        $display("[TB] FAIL single_busy n=%0d got=%b exp=%b", off + 1, busy, exp_busy);
      end
    end
    pulse_in = 1'b0;
  endtask

  // Level held 20 cycles is one event only.
  task automatic test_held_input();
    logic pend_seen;
    pend_seen = 1'b0;
    blinks    = 0;
    for (int off = 0; off < 30; off++) begin
      pulse_in = (off < 20);
      step();
      if (dut.pending !== 3'd0) pend_seen = 1'b1;
      if (off + 1 == 9) begin
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("[TB] FAIL held_busy n=9 got=%b exp=0", busy);
        end
      end
    end
    pulse_in = 1'b0;
    checks++;
    if (pend_seen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL held_pending got=nonzero exp=0");
    end
    checks++;
    if (blinks != 1) begin
      failures++;
      $display("[TB] FAIL held_blinks got=%0d exp=1", blinks);
    end
  endtask

  // Pulses at 0,2,4: blinks rise at 1,9,17; busy through 24.
  task automatic test_queueing();
    logic exp_led, exp_busy;
    int   n;
    blinks = 0;
    for (int off = 0; off < 30; off++) begin
      pulse_in = (off == 0) || (off == 2) || (off == 4);
      step();
      n = off + 1;
      exp_led  = ((n >= 1 && n <= 4) || (n >= 9 && n <= 12) || (n >= 17 && n <= 20))
                 ? LED_ON : LED_OFF;
      exp_busy = (n <= 24);
      checks++;
      if (led_out !== exp_led) begin
        failures++;
        $display("[TB] FAIL queue_led n=%0d got=%b exp=%b", n, led_out, exp_led);
      end
      checks++;
      if (busy !== exp_busy) begin
        failures++;
        $display("[TB] FAIL queue_busy n=%0d got=%b exp=%b", n, busy, exp_busy);
      end
    end
    pulse_in = 1'b0;
    checks++;
    if (blinks != 3) begin
      failures++;
      $display("[TB] FAIL queue_blinks got=%0d exp=3", blinks);
    end
  endtask

  // Pending=1 and a new pulse on the last OFF cycle (8): blink 2 at 9 with pending still 1.
  task automatic test_simultaneous_consume();
    int n;
    blinks = 0;
    for (int off = 0; off < 30; off++) begin
      pulse_in = (off == 0) || (off == 2) || (off == 8);
      step();
      n = off + 1;
      if (n == 8 || n == 9) begin
        checks++;
        if (dut.pending !== 3'd1) begin
          failures++;
          $display("[TB] FAIL simul_pending n=%0d got=%0d exp=1", n, dut.pending);
        end
      end
      if (n == 9 || n == 17) begin
        checks++;
        if (led_out !== LED_ON) begin
          failures++;
          $display("[TB] FAIL simul_led n=%0d got=%b exp=%b", n, led_out, LED_ON);
        end
      end
      if (n == 24 || n == 25) begin
        checks++;
        if (busy !== (n == 24)) begin
          failures++;
          $display("[TB] FAIL simul_busy n=%0d got=%b exp=%b", n, busy, (n == 24));
        end
      end
    end
    pulse_in = 1'b0;
    checks++;
    if (blinks != 3) begin
      failures++;
      $display("[TB] FAIL simul_blinks got=%0d exp=3", blinks);
    end
  endtask

  // Pulses at 0,2,..,20; consumes at 8 and 16 coincide with pulses, so pending hits 7
  // at cycle 19 and the pulse at 20 is dropped. 3 started + 7 queued = 10 blinks, idle at 81.
  task automatic test_overflow();
    int n;
    do_reset();
    for (int off = 0; off < 90; off++) begin
      pulse_in = (off <= 20) && (off % 2 == 0);
      step();
      n = off + 1;
      if (n == 20) begin
        checks++;
        if (overflow !== 1'b0) begin
          failures++;
          $display("[TB] FAIL ovf_early n=20 got=%b exp=0", overflow);
        end
      end
      if (n == 21) begin
        checks++;
        if (overflow !== 1'b1) begin
          failures++;
          $display("[TB] FAIL ovf_set n=21 got=%b exp=1", overflow);
        end
        checks++;
        if (dut.pending !== 3'd7) begin
          failures++;
          $display("[TB] FAIL ovf_pending n=21 got=%0d exp=7", dut.pending);
        end
      end
      if (n == 80 || n == 81) begin
        checks++;
        if (busy !== (n == 80)) begin
          failures++;
          $display("[TB] FAIL ovf_busy n=%0d got=%b exp=%b", n, busy, (n == 80));
        end
      end
    end
    pulse_in = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf_sticky got=%b exp=1", overflow);
    end
    checks++;
    if (blinks != 10) begin
      failures++;
      $display("[TB] FAIL ovf_blinks got=%0d exp=10", blinks);
    end
  endtask

  // Reset in the middle of ON cycle 2 clears everything at once; a fresh pulse then works.
  task automatic test_reset_mid_on();
    logic exp_led, exp_busy;
    pulse_in = 1'b1;
    step();
    pulse_in = 1'b0;
    step();
    checks++;
    if (led_out !== LED_ON) begin
      failures++;
      $display("[TB] FAIL midrst_pre_led got=%b exp=%b", led_out, LED_ON);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (led_out !== LED_OFF) begin
      failures++;
      $display("[TB] FAIL midrst_led got=%b exp=%b", led_out, LED_OFF);
    end
    checks++;
    if (busy !== 1'b0 || overflow !== 1'b0 || dut.pending !== 3'd0) begin
      failures++;
      $display("[TB] FAIL midrst_state got=busy%b/ovf%b/pend%0d exp=busy0/ovf0/pend0",
               busy, overflow, dut.pending);
    end
    step();
    reset = 1'b0;
    step();
    led_prev = led_out;
    for (int off = 0; off < 10; off++) begin
      pulse_in = (off == 0);
      step();
      exp_led  = ((off + 1) <= 4) ? LED_ON : LED_OFF;
      exp_busy = ((off + 1) <= 8);
      checks++;
      if (led_out !== exp_led || busy !== exp_busy) begin
        failures++;
        $display("[TB] FAIL midrst_fresh n=%0d got=led%b/busy%b exp=led%b/busy%b",
                 off + 1, led_out, busy, exp_led, exp_busy);
      end
    end
    pulse_in = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    pulse_in = 1'b0;
    test_reset();
    test_single_pulse();
    test_held_input();
    test_queueing();
    test_simultaneous_consume();
    test_overflow();
    test_reset_mid_on();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
